mem_responder: RTL
==================

Name: mem_responder

Overview:
Byte-wide memory responder for the 8-bit multicycle MIPS core. It answers the controller's memread/memwrite requests with a configurable read latency and a one-cycle ready pulse. It also flags illegal request combinations. A loader port preloads program/data bytes while the core is idle. It sits between the datapath's address mux (PC or ALUOut) and the instruction/data byte path.

Parameters:
WIDTH, 8, data byte width
AWIDTH, 8, address width from datapath
DEPTH, 256, number of bytes stored; must be a power of 2 and at most 2^AWIDTH
WAIT, 2, extra wait-state cycles inserted on reads (0 allowed)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
memread  in  1  read request from controller
memwrite  in  1  write request from controller
adr  in  AWIDTH  byte address
writedata  in  WIDTH  byte to store
memdata  out  WIDTH  registered read data
ready  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse: memread and memwrite both high at acceptance
load_en  in  1  loader write strobe
load_adr  in  AWIDTH  loader address
load_data  in  WIDTH  loader byte

Behaviour:
- Reset (rst low, asynchronous): state IDLE; memdata=0, ready=0, err=0; wait counter=0. Array contents are not cleared.
- States: IDLE, RWAIT, RDONE, WDONE, EDONE.
- Index = low log2(DEPTH) bits of the address. Higher bits are ignored, so addresses wrap and alias.
- IDLE priority at each rising edge:
  - load_en=1: mem[load_adr] <= load_data; CPU request ignored this edge; stay IDLE; no ready.
  - memread=1 and memwrite=1: no access; go to EDONE.
  - memwrite=1: mem[adr] <= writedata at this edge; go to WDONE.
  - memread=1: latch adr; counter <= WAIT; go to RWAIT if WAIT>0, else RDONE.
  - Otherwise: stay IDLE.
- RWAIT: decrement counter each cycle. When it reaches 1, go to RDONE. Exactly WAIT cycles are spent in RWAIT.
- Entering RDONE: memdata <= mem[latched adr]; ready=1 for that cycle only; next state is IDLE.
- Read latency: ready and valid memdata appear WAIT+1 cycles after the accepting edge. With WAIT=0, they appear the cycle after acceptance.
- WDONE: ready=1 for one cycle, then IDLE. memdata is unchanged.
- EDONE: ready=1 and err=1 for one cycle, then IDLE. Array and memdata are unchanged.
- memdata holds its last value outside RDONE.
- Requests and load_en arriving outside IDLE are ignored. There is no queuing. The requester must re-assert (or hold) the request until it sees ready.
- After a ready cycle the block returns to IDLE. A still-asserted request is accepted on the next edge, so the minimum spacing between accesses is 2 cycles.
- Inputs change during RWAIT: no effect, because the address is latched.
- Reset during RWAIT: the read is discarded and no ready is issued. A write is committed at its accepting edge, so it is retained even if reset arrives in WDONE.
- ready and err are registered outputs (decoded from registered state), never combinational from inputs.

Decomposition:
- Shared package mem_pkg: state encoding constants (IDLE=3'd0, RWAIT=3'd1, RDONE=3'd2, WDONE=3'd3, EDONE=3'd4) and default WIDTH/AWIDTH.
- One sub-module, mem_array: DEPTH x WIDTH storage with synchronous single write port and asynchronous read. The write port is muxed between loader and CPU by the parent.
- mem_responder holds the FSM, wait counter, address latch and memdata register.

Test Plan:
- Loader writes 0xA5 to 0x10, then memread adr=0x10 with WAIT=2 -> ready pulses exactly 3 cycles after acceptance; memdata=0xA5; err=0.
- memwrite adr=0x20 data=0x3C, then memread 0x20 with WAIT=0 -> write ready 1 cycle after acceptance; read ready 1 cycle after its acceptance with memdata=0x3C.
- memread and memwrite both high, adr=0x20 -> ready=1 and err=1 for one cycle; a subsequent read of 0x20 still returns 0x3C.
- Drive rst low 1 cycle after accepting a read with WAIT=3 -> memdata=0, ready=0 immediately; no ready pulse follows; the next read completes normally.
- DEPTH=64: write 0x77 to adr 0x41, read adr 0x01 -> memdata=0x77 (aliasing).
- load_en and memread asserted together in IDLE -> loader write occurs, no ready that cycle; the read is accepted on the following edge once load_en drops.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the byte-wide memory responder.
// Provides the FSM state encoding and the default data/address widths.
package mem_pkg;

   localparam int unsigned DefWidth  = 8;
   localparam int unsigned DefAwidth = 8;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StRwait = 3'd1,
      StRdone = 3'd2,
      StWdone = 3'd3,
      StEdone = 3'd4
   } state_e;

endpackage

// File: rtl/mem_array.sv
// DEPTH x WIDTH byte storage: one synchronous write port, one asynchronous read port.
// Contents have no reset.
// Ports:
//   clk    - write clock (rising edge)
//   we     - write enable
//   waddr  - write index
//   wdata  - write data
//   raddr  - read index
//   rdata  - combinational read data
module mem_array #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 256,
   parameter int unsigned IDXW  = 8
) (
   input  logic             clk,
   input  logic             we,
   input  logic [IDXW-1:0]  waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [IDXW-1:0]  raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Byte-wide memory responder for the multicycle MIPS core.
// Accepts memread/memwrite in IDLE, inserts WAIT read wait-states, pulses ready
// for one cycle on completion and err when both requests arrive together.
// A loader port writes the array while idle and has priority over the CPU.
// Ports:
//   clk, rst                   - clock, asynchronous active-low reset
//   memread, memwrite          - CPU request strobes
//   adr, writedata             - CPU byte address and store data
//   memdata                    - registered read data
//   ready, err                 - one-cycle completion / illegal-request pulses
//   load_en, load_adr, load_data - loader write port
module mem_responder
   import mem_pkg::*;
#(
   parameter int unsigned WIDTH  = DefWidth,
   parameter int unsigned AWIDTH = DefAwidth,
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned WAIT   = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              memread,
   input  logic              memwrite,
   input  logic [AWIDTH-1:0] adr,
   input  logic [WIDTH-1:0]  writedata,
   output logic [WIDTH-1:0]  memdata,
   output logic              ready,
   output logic              err,
   input  logic              load_en,
   input  logic [AWIDTH-1:0] load_adr,
   input  logic [WIDTH-1:0]  load_data
);

   localparam int unsigned IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW   = (WAIT > 1) ? $clog2(WAIT + 1) : 1;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [IDXW-1:0]  adr_q, adr_d;
   logic [WIDTH-1:0] memdata_q, memdata_d;

   logic             idle;
   logic             accept_rd;
   logic             we;
   logic [IDXW-1:0]  waddr;
   logic [WIDTH-1:0] wdata;
   logic [IDXW-1:0]  raddr;
   logic [WIDTH-1:0] rdata;

   // Upper address bits are ignored so addresses alias modulo DEPTH.
   logic unused_adr;
   assign unused_adr = ^{adr, load_adr};

   assign idle      = (state_q == StIdle);
   assign accept_rd = idle && !load_en && memread && !memwrite;

   // Writes commit on the accepting edge, so a reset in WDONE cannot lose them.
   assign we    = idle && (load_en || (memwrite && !memread));
   assign waddr = load_en ? load_adr[IDXW-1:0] : adr[IDXW-1:0];
   assign wdata = load_en ? load_data : writedata;

   // With WAIT=0 RDONE is entered on the accepting edge, before adr_q is valid.
   assign raddr = idle ? adr[IDXW-1:0] : adr_q;

   mem_array #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .IDXW  (IDXW)
   ) u_mem_array (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (raddr),
      .rdata (rdata)
   );

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         adr_q     <= '0;
         memdata_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         adr_q     <= adr_d;
         memdata_q <= memdata_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (load_en) begin
               state_d = StIdle;
            end else if (memread && memwrite) begin
               state_d = StEdone;
            end else if (memwrite) begin
               state_d = StWdone;
            end else if (memread) begin
               state_d = (WAIT == 0) ? StRdone : StRwait;
            end
         end
         StRwait: begin
            if (cnt_q <= CW'(1)) begin
               state_d = StRdone;
            end
         end
         StRdone, StWdone, StEdone: state_d = StIdle;
         default:                   state_d = StIdle;
      endcase
   end

   // Datapath next-state: wait counter, address latch, read data register
   always_comb begin
      cnt_d     = cnt_q;
      adr_d     = adr_q;
      memdata_d = memdata_q;
      if (accept_rd) begin
         cnt_d = CW'(WAIT);
         adr_d = adr[IDXW-1:0];
      end else if (state_q == StRwait) begin
         cnt_d = cnt_q - CW'(1);
      end
      if (state_d == StRdone) begin
         memdata_d = rdata;
      end
   end

   // Outputs decoded from registered state
   always_comb begin
      ready = 1'b0;
      err   = 1'b0;
      unique case (state_q)
         StRdone, StWdone: ready = 1'b1;
         StEdone: begin
            ready = 1'b1;
            err   = 1'b1;
         end
         default: begin
            ready = 1'b0;
            err   = 1'b0;
         end
      endcase
   end

   assign memdata = memdata_q;

endmodule
